// File: rtl/muntjac_pkg.sv
// muntjac_pkg: shared core types used by the fetch/decode path.
// Contents:
//   exc_cause_e, exception_t  - trap cause and trap value carried with an instruction
//   if_reason_e               - reason the fetcher started fetching at this pc
//   fetched_instr_t           - one fetched instruction as handed to decode
//   IQ_DEPTH_DEFAULT          - default instr_queue depth for top-level instantiation
package muntjac_pkg;

    localparam int unsigned FETCH_PC_W       = 64;
    localparam int unsigned IQ_DEPTH_DEFAULT = 4;

    typedef enum logic [3:0] {
        EXC_CAUSE_INSN_ADDR_MISA     = 4'd0,
        EXC_CAUSE_INSN_ACCESS_FAULT  = 4'd1,
        EXC_CAUSE_ILLEGAL_INSN       = 4'd2,
        EXC_CAUSE_BREAKPOINT         = 4'd3,
        EXC_CAUSE_LOAD_MISALIGN      = 4'd4,
        EXC_CAUSE_LOAD_ACCESS_FAULT  = 4'd5,
        EXC_CAUSE_STORE_MISALIGN     = 4'd6,
        EXC_CAUSE_STORE_ACCESS_FAULT = 4'd7,
        EXC_CAUSE_ECALL_UMODE        = 4'd8,
        EXC_CAUSE_ECALL_SMODE        = 4'd9,
        EXC_CAUSE_ECALL_MMODE        = 4'd11,
        EXC_CAUSE_INSN_PAGE_FAULT    = 4'd12,
        EXC_CAUSE_LOAD_PAGE_FAULT    = 4'd13,
        EXC_CAUSE_STORE_PAGE_FAULT   = 4'd15
    } exc_cause_e;

    typedef struct packed {
        exc_cause_e              cause;
        logic [FETCH_PC_W-1:0]   tval;
    } exception_t;

    typedef enum logic [3:0] {
        IF_PREFETCH     = 4'b0000,
        IF_MISPREDICT   = 4'b0001,
        IF_PROT_CHANGED = 4'b0011,
        IF_SATP_CHANGED = 4'b0111,
        IF_FENCE_I      = 4'b1011
    } if_reason_e;

    typedef struct packed {
        logic [31:0]             instr_word;
        logic [FETCH_PC_W-1:0]   pc;
        if_reason_e              if_reason;
        logic                    ex_valid;
        exception_t              exception;
    } fetched_instr_t;

endpackage

// File: rtl/instr_queue.sv
// instr_queue: decoupling queue between the fetcher and decode.
// Absorbs fetch/decode rate mismatch, drops everything on a redirect and
// refuses new input after a faulting fetch until the next flush.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   i_flush              redirect: empties the queue, swallows the offered input
//   in_valid/in_ready    fetcher side handshake, in_instr is the payload
//   out_valid/out_ready  decode side handshake, out_instr is the head entry
//   o_count              occupancy 0..DEPTH
module instr_queue
    import muntjac_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    parameter int unsigned XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  fetched_instr_t             in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output fetched_instr_t             out_instr,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_queue: DEPTH must be a power of two >= 2");
    end
    if (XLEN != FETCH_PC_W) begin : g_bad_xlen
        $error("instr_queue: XLEN must match the pc width of fetched_instr_t");
    end

    fetched_instr_t  mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            poisoned_q, poisoned_d;

    logic empty, full, enq, deq;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // During a flush the stale fetcher output is accepted and thrown away.
    // in_ready deliberately ignores out_ready: no write into a full queue.
    assign in_ready  = i_flush || (!full && !poisoned_q);
    assign out_valid = !empty && !i_flush;
    assign out_instr = mem_q[rptr_q[AW-1:0]];
    assign o_count   = wptr_q - rptr_q;

    assign enq = in_valid && in_ready && !i_flush;
    assign deq = out_valid && out_ready;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        poisoned_d = poisoned_q;
        if (i_flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            poisoned_d = 1'b0;
        end else begin
            if (enq) wptr_d = wptr_q + PTR_ONE;
            if (deq) rptr_d = rptr_q + PTR_ONE;
            // Once a faulting fetch is in, nothing behind it is meaningful.
            if (enq && in_instr.ex_valid) poisoned_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            poisoned_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            poisoned_q <= poisoned_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (enq) begin
            mem_q[wptr_q[AW-1:0]] <= in_instr;
        end
    end

`ifndef SYNTHESIS
    // in_valid may drop across a flush; no stability check on the input side.
    a_no_write_full: assert property (@(posedge clk) disable iff (!resetn)
        enq |-> !full);
    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        o_count <= PW'(DEPTH));
    a_head_stable: assert property (@(posedge clk) disable iff (!resetn)
        (out_valid && !out_ready && !i_flush) |=> $stable(out_instr));
`endif

endmodule
